// File: rtl/relu_result_collector.sv
// ---------------------------------------------------------------------------
// relu_result_collector
//   Collects (index, value) results from a relu_cell stream into one of two
//   CELL_AMOUNT-entry ping-pong banks. A bank that holds every index is
//   drained in index order as {valid, value} words using a valid/ready
//   handshake. While one bank drains, the other can fill.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   input_index     slot index of the incoming result
//   input_value     ReLU output value
//   input_enable    result present this cycle (no backpressure)
//   output_ready    downstream accepts output_data this cycle
//   output_data     [DATA_WIDTH]=valid, [DATA_WIDTH-1:0]=value
//   output_last     marks element CELL_AMOUNT-1 of a vector
//   range_error     sticky: enable with index >= CELL_AMOUNT
//   dup_error       sticky: write to an already-filled slot
//   overrun_error   sticky: write dropped, no bank free to fill
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// relu_collector_bank
//   One storage bank: values, per-slot valid bits and the bank state
//   EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY. The top decides when a
//   bank is written, starts draining, or is released.
//
// Ports
//   wr_i/slot_i/val_i  accepted write into this bank
//   start_i            bank selected by the drain side (FULL -> DRAINING)
//   release_i          last element handshaken (DRAINING -> EMPTY)
//   state_o            current bank state
//   vld_o              per-slot valid bits
//   data_o             stored values
//   complete_o         this cycle's write fills the final empty slot
// ---------------------------------------------------------------------------
module relu_collector_bank #(
  parameter int DATA_WIDTH  = 32,
  parameter int CELL_AMOUNT = 4,
  parameter int IDX_W       = 2
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  wr_i,
  input  logic [IDX_W-1:0]                      slot_i,
  input  logic [DATA_WIDTH-1:0]                 val_i,
  input  logic                                  start_i,
  input  logic                                  release_i,
  output logic [1:0]                            state_o,
  output logic [CELL_AMOUNT-1:0]                vld_o,
  output logic [CELL_AMOUNT-1:0][DATA_WIDTH-1:0] data_o,
  output logic                                  complete_o
);
  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_FILLING = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  logic [1:0]                             state_q, state_d;
  logic [CELL_AMOUNT-1:0]                 vld_q, vld_d;
  logic [CELL_AMOUNT-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [CELL_AMOUNT-1:0]                 slot_oh;

  assign slot_oh    = CELL_AMOUNT'(1) << slot_i;
  // A rewrite of an already-valid slot never completes the bank.
  assign complete_o = wr_i & ~vld_q[slot_i] & (&(vld_q | slot_oh));

  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    data_d  = data_q;
    if (wr_i) begin
      data_d[slot_i] = val_i;
      vld_d          = vld_q | slot_oh;
      state_d        = complete_o ? ST_FULL : ST_FILLING;
    end
    if (start_i) state_d = ST_DRAIN;
    if (release_i) begin
      state_d = ST_EMPTY;
      vld_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      vld_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
    end
  end

  assign state_o = state_q;
  assign vld_o   = vld_q;
  assign data_o  = data_q;
endmodule

module relu_result_collector #(
  parameter int DATA_WIDTH  = 32,
  parameter int CELL_AMOUNT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] input_index,
  input  logic [DATA_WIDTH-1:0] input_value,
  input  logic                  input_enable,
  input  logic                  output_ready,
  output logic [DATA_WIDTH:0]   output_data,
  output logic                  output_last,
  output logic                  range_error,
  output logic                  dup_error,
  output logic                  overrun_error
);
  localparam int IDX_W = (CELL_AMOUNT > 1) ? $clog2(CELL_AMOUNT) : 1;
  localparam int NB    = 2;

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_FILLING = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELL_AMOUNT - 1);

  // bank outputs
  logic [NB-1:0][1:0]                             bank_st;
  logic [NB-1:0][CELL_AMOUNT-1:0]                 bank_vld;
  logic [NB-1:0][CELL_AMOUNT-1:0][DATA_WIDTH-1:0] bank_data;
  logic [NB-1:0]                                  bank_cmpl;
  logic [NB-1:0]                                  bank_wr, bank_start, bank_rel;

  // control state
  logic                  fill_sel_q, fill_sel_d;
  logic                  drain_sel_q, drain_sel_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [DATA_WIDTH:0]   out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic                  range_q, range_d;
  logic                  dup_q, dup_d;
  logic                  ovr_q, ovr_d;

  logic [IDX_W-1:0] slot, ptr_nxt;
  logic             in_range, fill_open, wr_ok;
  logic             xfer, last_xfer, draining, can_start, start_any, start_sel;
  logic             fill_done, other_free;

  assign in_range  = input_index < DATA_WIDTH'(CELL_AMOUNT);
  assign slot      = input_index[IDX_W-1:0];
  assign fill_open = (bank_st[fill_sel_q] == ST_EMPTY) || (bank_st[fill_sel_q] == ST_FILLING);
  assign wr_ok     = input_enable & in_range & fill_open;

  assign xfer      = out_data_q[DATA_WIDTH] & output_ready;
  assign last_xfer = xfer & (ptr_q == LAST_IDX);
  assign draining  = bank_st[drain_sel_q] == ST_DRAIN;
  assign ptr_nxt   = ptr_q + IDX_W'(1);
  // A new drain may begin when idle, or on the edge the current one finishes
  // so back-to-back vectors leave no bubble.
  assign can_start = ~draining | last_xfer;

  always_comb begin
    bank_start = '0;
    if (can_start) begin
      if (bank_st[0] == ST_FULL)      bank_start[0] = 1'b1;
      else if (bank_st[1] == ST_FULL) bank_start[1] = 1'b1;
    end
  end
  assign start_any = |bank_start;
  assign start_sel = bank_start[1];

  for (genvar b = 0; b < NB; b++) begin : g_bank
    assign bank_wr[b]  = wr_ok & (fill_sel_q == 1'(b));
    assign bank_rel[b] = last_xfer & (drain_sel_q == 1'(b));

    relu_collector_bank #(
      .DATA_WIDTH  (DATA_WIDTH),
      .CELL_AMOUNT (CELL_AMOUNT),
      .IDX_W       (IDX_W)
    ) u_bank (
      .clk        (clk),
      .reset      (reset),
      .wr_i       (bank_wr[b]),
      .slot_i     (slot),
      .val_i      (input_value),
      .start_i    (bank_start[b]),
      .release_i  (bank_rel[b]),
      .state_o    (bank_st[b]),
      .vld_o      (bank_vld[b]),
      .data_o     (bank_data[b]),
      .complete_o (bank_cmpl[b])
    );
  end

  // Fill bank moves on once it is complete (or already full) and the other
  // bank is, or is becoming, empty on this edge.
  assign fill_done  = bank_cmpl[fill_sel_q] || (bank_st[fill_sel_q] == ST_FULL) ||
                      (bank_st[fill_sel_q] == ST_DRAIN);
  assign other_free = (bank_st[~fill_sel_q] == ST_EMPTY) || bank_rel[~fill_sel_q];

  always_comb begin
    fill_sel_d  = fill_sel_q;
    drain_sel_d = drain_sel_q;
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    range_d     = range_q | (input_enable & ~in_range);
    ovr_d       = ovr_q   | (input_enable & in_range & ~fill_open);
    dup_d       = dup_q   | (wr_ok & bank_vld[fill_sel_q][slot]);

    if (fill_done && other_free) fill_sel_d = ~fill_sel_q;

    if (start_any) begin
      drain_sel_d = start_sel;
      ptr_d       = '0;
      out_data_d  = {1'b1, bank_data[start_sel][0]};
      out_last_d  = 1'b0;
    end else if (xfer && !last_xfer) begin
      ptr_d       = ptr_nxt;
      out_data_d  = {1'b1, bank_data[drain_sel_q][ptr_nxt]};
      out_last_d  = (ptr_nxt == LAST_IDX);
    end else if (last_xfer) begin
      ptr_d       = '0;
      out_data_d  = '0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_sel_q  <= 1'b0;
      drain_sel_q <= 1'b0;
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      range_q     <= 1'b0;
      dup_q       <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      fill_sel_q  <= fill_sel_d;
      drain_sel_q <= drain_sel_d;
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      range_q     <= range_d;
      dup_q       <= dup_d;
      ovr_q       <= ovr_d;
    end
  end

  assign output_data   = out_data_q;
  assign output_last   = out_last_q;
  assign range_error   = range_q;
  assign dup_error     = dup_q;
  assign overrun_error = ovr_q;
endmodule
